// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Bubble encoding: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequential PC increment in bytes.
  localparam int unsigned PC_STEP = 4;

  // Fetch controller states.
  //   FETCH : issue a request for the current PC
  //   WAIT  : request outstanding, waiting for the response
  //   HOLD  : response captured while the pipeline is stalled
  //   DROP  : request outstanding but already squashed by a redirect
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush inserts a bubble, stall holds, load captures
// a new instruction, and an idle cycle with nothing to load also bubbles.
module ifid_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr
);
  import fetch_pkg::*;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Next IF/ID contents: flush beats stall, stall beats load.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (stall) begin
      // hold every field
    end else if (load) begin
      valid_d    = 1'b1;
      pc_d       = load_pc;
      pc_plus4_d = load_pc + XLEN'(PC_STEP);
      instr_d    = load_instr;
    end else begin
      // pc fields keep stale values; only valid/instr matter for a bubble
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  // IF/ID state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= XLEN'(PC_STEP);
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign ifid_valid    = valid_q;
  assign ifid_pc       = pc_q;
  assign ifid_pc_plus4 = pc_plus4_q;
  assign ifid_instr    = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch controller: one outstanding imem request, next-PC select
// for program_counter, and the IF/ID register fill with stall/redirect.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  output logic [XLEN-1:0] pc_update,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr
);
  import fetch_pkg::*;

  // Clears the two byte-offset bits so program_counter always gets a word address.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_e          state_q, state_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic            req_c, en_c, load_c;
  logic [XLEN-1:0] upd_c, load_instr_c;
  logic [XLEN-1:0] seq_pc, tgt_pc;

  assign seq_pc = (pc + XLEN'(PC_STEP)) & ALIGN_MASK;  // wraps mod 2^XLEN
  assign tgt_pc = redirect_target & ALIGN_MASK;

  // Next-state, request and next-PC selection; redirect outranks stall everywhere.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    req_c        = 1'b0;
    en_c         = 1'b0;
    upd_c        = '0;
    load_c       = 1'b0;
    load_instr_c = imem_rdata;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          en_c  = 1'b1;
          upd_c = tgt_pc;
        end else begin
          req_c   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          en_c    = 1'b1;
          upd_c   = tgt_pc;
          // a response still in flight must be swallowed before fetching again
          state_d = imem_valid ? FETCH : DROP;
        end else if (imem_valid && !stall) begin
          load_c  = 1'b1;
          en_c    = 1'b1;
          upd_c   = seq_pc;
          state_d = FETCH;
        end else if (imem_valid) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          en_c    = 1'b1;
          upd_c   = tgt_pc;
          hold_d  = '0;
          state_d = FETCH;
        end else if (!stall) begin
          load_c       = 1'b1;
          load_instr_c = hold_q;
          en_c         = 1'b1;
          upd_c        = seq_pc;
          state_d      = FETCH;
        end
      end
      DROP: begin
        // latest redirect target wins; leaving DROP depends only on the response
        if (redirect) begin
          en_c  = 1'b1;
          upd_c = tgt_pc;
        end
        if (imem_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // FSM state and hold buffer with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Strobes are combinational but suppressed while reset is held.
  assign imem_req  = req_c & ~reset;
  assign imem_addr = pc;
  assign pc_en     = en_c & ~reset;
  assign pc_update = reset ? '0 : upd_c;

  ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk           (clk),
    .reset         (reset),
    .flush         (redirect),
    .stall         (stall),
    .load          (load_c),
    .load_pc       (pc),
    .load_instr    (load_instr_c),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: models program_counter and a
// variable-latency instruction memory; expected IF/ID entries go through a
// scoreboard queue.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] pc_update;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;
  int mem_cnt;
  logic [31:0] mem_addr;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .pc_update(pc_update),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  // program_counter model
  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (pc_en) pc <= pc_update;
  end

  // Instruction memory: response mem_lat cycles after the request, reset with the core.
  always @(posedge clk) begin
    if (reset) begin
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (imem_req) begin
      mem_cnt  <= mem_lat;
      mem_addr <= imem_addr;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end
  assign imem_valid = (mem_cnt == 1);
  assign imem_rdata = imem_valid ? instr_of(mem_addr) : 32'hDEAD_BEEF;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.instr = instr_of(a);
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ifid_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL rst_pc_en: got %b want 0", pc_en); end
    n_cmp++; if (pc_update !== 32'h0) begin n_err++; $display("FAIL rst_pc_update: got %h want 0", pc_update); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", ifid_valid); end
    n_cmp++; if (ifid_instr !== NOP) begin n_err++; $display("FAIL rst_instr: got %h want %h", ifid_instr, NOP); end
    n_cmp++; if (ifid_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", ifid_pc); end
    n_cmp++; if (ifid_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc4: got %h want 4", ifid_pc_plus4); end
  endtask

  task automatic test_basic();
    exp_t e;
    cyc(); reset = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_addr: got %h want 0", imem_addr); end
    push_exp(32'h0);
    cyc();
    n_cmp++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL basic_pc_en: got %b want 1", pc_en); end
    n_cmp++; if (pc_update !== 32'h4) begin n_err++; $display("FAIL basic_pc_update: got %h want 4", pc_update); end
    cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", ifid_valid); end
    n_cmp++; if (ifid_pc !== e.pc) begin n_err++; $display("FAIL basic_ifid_pc: got %h want %h", ifid_pc, e.pc); end
    n_cmp++; if (ifid_instr !== e.instr) begin n_err++; $display("FAIL basic_instr: got %h want %h", ifid_instr, e.instr); end
    n_cmp++; if (ifid_pc_plus4 !== e.pc + 32'd4) begin n_err++; $display("FAIL basic_pc4: got %h want %h", ifid_pc_plus4, e.pc + 32'd4); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL b2b_req: got %b/%h want 1/4", imem_req, imem_addr); end
    n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL b2b_pc_en_gap: got %b want 0", pc_en); end
    push_exp(32'h4);
    cyc();
    n_cmp++; if (pc_en !== 1'b1 || pc_update !== 32'h8) begin n_err++; $display("FAIL b2b_update: got %b/%h want 1/8", pc_en, pc_update); end
    cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== e.pc) begin n_err++; $display("FAIL b2b_ifid: got %b/%h want 1/%h", ifid_valid, ifid_pc, e.pc); end
    n_cmp++; if (ifid_instr !== e.instr) begin n_err++; $display("FAIL b2b_instr: got %h want %h", ifid_instr, e.instr); end
  endtask

  task automatic test_stall();
    exp_t e;
    stall = 1'b1; #1;
    push_exp(32'h8);
    cyc();
    n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL stall_wait_pc_en: got %b want 0", pc_en); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL stall_hold_pc_en: got %b want 0", pc_en); end
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin n_err++; $display("FAIL stall_ifid_held: got %b/%h want 1/4", ifid_valid, ifid_pc); end
    end
    cyc(); stall = 1'b0; #1;
    n_cmp++; if (pc_en !== 1'b1 || pc_update !== 32'hC) begin n_err++; $display("FAIL stall_release: got %b/%h want 1/c", pc_en, pc_update); end
    cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== e.pc) begin n_err++; $display("FAIL stall_ifid: got %b/%h want 1/%h", ifid_valid, ifid_pc, e.pc); end
    n_cmp++; if (ifid_instr !== e.instr) begin n_err++; $display("FAIL stall_instr: got %h want %h", ifid_instr, e.instr); end
  endtask

  task automatic test_redirect_drop();
    exp_t e;
    bit ok;
    mem_lat = 3;
    cyc(); redirect = 1'b1; redirect_target = 32'h100; #1;
    n_cmp++; if (pc_en !== 1'b1 || pc_update !== 32'h100) begin n_err++; $display("FAIL drop_redirect: got %b/%h want 1/100", pc_en, pc_update); end
    cyc(); redirect = 1'b0; #1;
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_err++; $display("FAIL drop_bubble: got %b/%h want 0/%h", ifid_valid, ifid_instr, NOP); end
    n_cmp++; if (pc_en !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL drop_idle: got %b/%b want 0/0", pc_en, imem_req); end
    cyc();
    n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL drop_late_pc_en: got %b want 0", pc_en); end
    cyc();
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL drop_late_load: got %b want 0", ifid_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL drop_refetch: got %b/%h want 1/100", imem_req, imem_addr); end
    mem_lat = 1;
    push_exp(32'h100);
    wait_valid(6, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL drop_timeout: got no ifid_valid want 1"); end
    e = sb.pop_front();
    n_cmp++; if (ifid_pc !== e.pc || ifid_instr !== e.instr) begin n_err++; $display("FAIL drop_target_ifid: got %h/%h want %h/%h", ifid_pc, ifid_instr, e.pc, e.instr); end
  endtask

  task automatic test_redirect_flush();
    exp_t e;
    cyc(); redirect = 1'b1; redirect_target = 32'h200; #1;
    n_cmp++; if (pc_en !== 1'b1 || pc_update !== 32'h200) begin n_err++; $display("FAIL coinc_redirect: got %b/%h want 1/200", pc_en, pc_update); end
    cyc(); redirect = 1'b0; #1;
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_err++; $display("FAIL coinc_bubble: got %b/%h want 0/%h", ifid_valid, ifid_instr, NOP); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL coinc_refetch: got %b/%h want 1/200", imem_req, imem_addr); end
    push_exp(32'h200);
    repeat (2) cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== e.pc) begin n_err++; $display("FAIL coinc_target_ifid: got %b/%h want 1/%h", ifid_valid, ifid_pc, e.pc); end
    stall = 1'b1; #1;
    cyc();
    n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL hold_enter_pc_en: got %b want 0", pc_en); end
    cyc();
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL hold_ifid_held: got %b want 1", ifid_valid); end
    redirect = 1'b1; redirect_target = 32'h300; #1;
    n_cmp++; if (pc_en !== 1'b1 || pc_update !== 32'h300) begin n_err++; $display("FAIL hold_redirect: got %b/%h want 1/300", pc_en, pc_update); end
    cyc(); redirect = 1'b0; stall = 1'b0; #1;
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_err++; $display("FAIL hold_flush: got %b/%h want 0/%h", ifid_valid, ifid_instr, NOP); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_err++; $display("FAIL hold_refetch: got %b/%h want 1/300", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_align();
    exp_t e;
    push_exp(32'h300);
    repeat (2) cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== e.pc) begin n_err++; $display("FAIL align_pre_ifid: got %b/%h want 1/%h", ifid_valid, ifid_pc, e.pc); end
    redirect = 1'b1; redirect_target = 32'h103; #1;
    n_cmp++; if (pc_en !== 1'b1 || pc_update !== 32'h100) begin n_err++; $display("FAIL align_update: got %b/%h want 1/100", pc_en, pc_update); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL align_no_req: got %b want 0", imem_req); end
    cyc(); redirect = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL align_fetch: got %b/%h want 1/100", imem_req, imem_addr); end
    push_exp(32'h100);
    repeat (2) cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_pc !== e.pc || ifid_instr !== e.instr) begin n_err++; $display("FAIL align_ifid: got %h/%h want %h/%h", ifid_pc, ifid_instr, e.pc, e.instr); end
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; #1;
    cyc(); redirect = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_fetch: got %b/%h want 1/fffffffc", imem_req, imem_addr); end
    push_exp(32'hFFFF_FFFC);
    cyc();
    n_cmp++; if (pc_en !== 1'b1 || pc_update !== 32'h0) begin n_err++; $display("FAIL wrap_update: got %b/%h want 1/0", pc_en, pc_update); end
    cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_pc !== e.pc || ifid_instr !== e.instr) begin n_err++; $display("FAIL wrap_ifid: got %h/%h want %h/%h", ifid_pc, ifid_instr, e.pc, e.instr); end
    n_cmp++; if (ifid_pc_plus4 !== e.pc + 32'd4) begin n_err++; $display("FAIL wrap_pc4: got %h want %h", ifid_pc_plus4, e.pc + 32'd4); end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    int lat;
    mem_lat = 3;
    repeat (3) cyc();
    reset = 1'b1; #1;
    n_cmp++; if (pc_en !== 1'b0 || pc_update !== 32'h0) begin n_err++; $display("FAIL rmid_force_pc: got %b/%h want 0/0", pc_en, pc_update); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_force_req: got %b want 0", imem_req); end
    cyc();
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_err++; $display("FAIL rmid_ifid: got %b/%h want 0/%h", ifid_valid, ifid_instr, NOP); end
    n_cmp++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rmid_ifid_pc: got %h/%h want 0/4", ifid_pc, ifid_pc_plus4); end
    n_cmp++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_err++; $display("FAIL rmid_strobes: got %b/%b want 0/0", imem_req, pc_en); end
    cyc(); reset = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_restart: got %b/%h want 1/0", imem_req, imem_addr); end
    push_exp(32'h0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      lat++;
      if (pc_en === 1'b1) break;
    end
    n_cmp++; if (lat != 3 || pc_update !== 32'h4) begin n_err++; $display("FAIL rmid_latency: got %0d/%h want 3/4", lat, pc_update); end
    cyc();
    e = sb.pop_front();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_instr !== e.instr) begin n_err++; $display("FAIL rmid_ifid_load: got %b/%h want 1/%h", ifid_valid, ifid_instr, e.instr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_redirect_drop();
    test_redirect_flush();
    test_wrap_align();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch controller sitting directly downstream of program_counter. It consumes program_counter's count and drives its en and pc_update.
- Issues one instruction-memory request per PC and captures the response.
- Fills the IF/ID pipeline register, honouring hazard-unit stalls and branch/jump redirects from EX.
- Holds at most one outstanding memory request.

Parameters:
- XLEN, 32, address/data width.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clk  in  1  core clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- pc  in  XLEN  current PC (program_counter count).
- pc_en  out  1  load strobe to program_counter en.
- pc_update  out  XLEN  next PC value to program_counter pc_update.
- imem_req  out  1  single-cycle request pulse.
- imem_addr  out  XLEN  request address, valid when imem_req=1.
- imem_valid  in  1  response strobe, arrives >=1 cycle after imem_req.
- imem_rdata  in  XLEN  instruction word, valid with imem_valid.
- stall  in  1  hazard unit: hold IF/ID and do not advance.
- redirect  in  1  taken branch/jump/flush from EX.
- redirect_target  in  XLEN  new PC when redirect=1.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  XLEN  PC of the IF/ID instruction.
- ifid_pc_plus4  out  XLEN  ifid_pc+4.
- ifid_instr  out  XLEN  instruction, or NOP_INSTR when invalid.

Behaviour:
- Reset (synchronous, active-high; priority over everything):
  - state=FETCH; ifid_valid=0; ifid_instr=NOP_INSTR; ifid_pc=0; ifid_pc_plus4=4.
  - imem_req=0; pc_en=0; pc_update=0; hold buffer cleared.
  - imem_req, pc_en and pc_update are combinational from state/inputs but forced to 0 while reset=1.
- Event priority: reset > redirect > stall > normal advance.
- Arithmetic: pc+4 wraps mod 2^XLEN. pc_update[1:0] is always 2'b00; redirect_target[1:0] is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc; next state WAIT.
  - On redirect: pc_en=1, pc_update=target, no request issued, stay FETCH.
- WAIT (request outstanding):
  - redirect & imem_valid: discard response; pc_en=1, pc_update=target; go FETCH.
  - redirect & !imem_valid: pc_en=1, pc_update=target; go DROP.
  - imem_valid & !stall: load IF/ID (valid=1, pc, pc+4, rdata) next edge; pc_en=1, pc_update=pc+4; go FETCH.
  - imem_valid & stall: capture rdata into hold buffer; go HOLD.
  - Otherwise stay WAIT.
- HOLD:
  - redirect: drop buffer; pc_en=1, pc_update=target; go FETCH.
  - !stall: load IF/ID from buffer; pc_en=1, pc_update=pc+4; go FETCH.
  - Otherwise stay HOLD.
- DROP:
  - Wait for imem_valid, discard it, go FETCH.
  - A further redirect in DROP: pc_en=1, pc_update=new target; stay DROP (latest target wins).
- IF/ID register update, per edge:
  - redirect: bubble (valid=0, instr=NOP_INSTR).
  - Else stall: hold all fields.
  - Else load: new instruction.
  - Else (no instruction available): bubble.
  - ifid_pc/ifid_pc_plus4 may hold stale values when valid=0.
- Throughput: one instruction per 2 cycles with a 1-cycle-latency memory (FETCH, WAIT). Long latency stays in WAIT indefinitely.
- pc_en is never asserted in consecutive cycles, except for back-to-back redirects.
- Reset mid-WAIT/DROP: a late imem_valid arriving after reset while in FETCH is ignored. The memory must also be reset.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH, WAIT, HOLD, DROP} (2 bits).
  - NOP_INSTR constant.
  - PC_STEP = 4.
- One sub-module: ifid_reg. It is the IF/ID pipeline register with load/stall/flush inputs and the reset values above.
- The FSM and next-PC select stay in fetch_stage.

Test Plan:
- Reset, pc=0x0, 1-cycle imem returning 0x00500093 -> cycle1 imem_req=1/addr=0x0; cycle2 pc_en=1, pc_update=0x4; IF/ID valid=1, pc=0x0, instr=0x00500093, pc_plus4=0x4.
- stall=1 for 3 cycles while response for pc=0x8 arrives -> state HOLD, pc_en=0, IF/ID unchanged. On release, IF/ID pc=0x8 and pc_update=0xC in the same cycle.
- redirect=1, target=0x100 in WAIT before response -> pc_en=1/pc_update=0x100, DROP. Late response discarded, IF/ID valid=0/instr=0x13. Next imem_addr=0x100.
- redirect coincident with imem_valid, and redirect during stall/HOLD -> response dropped, IF/ID bubble, next fetch at target (e.g. 0x200). Redirect overrides stall.
- pc=0xFFFFFFFC fetch, and redirect_target=0x103 -> pc_update=0x00000000 (wrap); target fetch imem_addr=0x100.
- Assert reset=1 mid-WAIT with 3-cycle memory -> all outputs reach the reset values at the next edge. No pc_en and no IF/ID load from the stale response.
